// File: rtl/afvip_rst_gen.sv
// Reset generator: async-assert / sync-deassert of rst_n plus a hold window and software reset sequencing.
// Optional status counter rst_count is enabled by defining AFVIP_RST_GEN_STATUS_EN.
module afvip_rst_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_rst_req,
  output logic       rst_out_n,
  output logic       sw_rst_ack,
  output logic       busy
`ifdef AFVIP_RST_GEN_STATUS_EN
  ,
  output logic [7:0] rst_count
`endif
);

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_SW_RST = 2'd3
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   req_q;
  logic                   rst_out_q, rst_out_d;
  logic                   ack_q, ack_d;
  logic                   accept;
  logic                   hold_done;

  assign accept    = sw_rst_req & ~req_q;
  assign hold_done = (cnt_q == HOLD_LAST);

  // Next-state decode; the chain's shifted value is used so HOLD is entered on the
  // same edge the last synchronizer stage captures 1, keeping latency at SYNC_STAGES+HOLD_CYCLES.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_out_d = rst_out_q;
    ack_d     = 1'b0;
    sync_d    = {sync_q[SYNC_STAGES-2:0], 1'b1};
    case (state_q)
      ST_ASSERT: begin
        rst_out_d = 1'b0;
        if (sync_d[SYNC_STAGES-1]) begin
          state_d = ST_HOLD;
          cnt_d   = 8'd0;
        end
      end
      ST_HOLD: begin
        rst_out_d = 1'b0;
        if (hold_done) begin
          state_d   = ST_RUN;
          rst_out_d = 1'b1;
          cnt_d     = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RUN: begin
        rst_out_d = 1'b1;
        if (accept) begin
          state_d   = ST_SW_RST;
          rst_out_d = 1'b0;
          cnt_d     = 8'd0;
        end
      end
      ST_SW_RST: begin
        rst_out_d = 1'b0;
        if (hold_done) begin
          state_d   = ST_RUN;
          rst_out_d = 1'b1;
          ack_d     = 1'b1;
          cnt_d     = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = ST_ASSERT;
        rst_out_d = 1'b0;
        cnt_d     = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ASSERT;
      sync_q    <= '0;
      cnt_q     <= 8'd0;
      req_q     <= 1'b0;
      rst_out_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      req_q     <= sw_rst_req;
      rst_out_q <= rst_out_d;
      ack_q     <= ack_d;
    end
  end

  assign rst_out_n  = rst_out_q;
  assign sw_rst_ack = ack_q;
  assign busy       = (state_q != ST_RUN);

`ifdef AFVIP_RST_GEN_STATUS_EN
  logic [7:0] rst_cnt_q, rst_cnt_d;

  // Counts SW_RST entries, saturating at 255.
  always_comb begin
    rst_cnt_d = rst_cnt_q;
    if ((state_q == ST_RUN) && accept && (rst_cnt_q != 8'hFF)) begin
      rst_cnt_d = rst_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt_q <= 8'd0;
    end else begin
      rst_cnt_q <= rst_cnt_d;
    end
  end

  assign rst_count = rst_cnt_q;
`endif

endmodule
